dmac_transfer_ctrl: RTL and testbench

- Sequencing engine of the DMAC; consumes the descriptor held in the DMAC register file (source, destination, size, start).
- Acquires the shared system bus through a request/grant handshake.
- Moves data one word at a time: read from source, then write to destination.
- Reports busy, done and a one-cycle interrupt pulse back to the register file and CPU.

---
 rtl/dmac_transfer_ctrl.sv | 107 ++++++++++
 tb/tb_dmac_transfer_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmac_transfer_ctrl.sv
// dmac_transfer_ctrl: DMAC sequencer moving data_size words from src to dst over a request/grant bus.
// Optional DMAC_PAUSE_EN adds a pause input that parks the engine in REQ with the bus released.
module dmac_transfer_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [SIZE_W-1:0] data_size,
  output logic              m_req,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              busy,
  output logic              done,
  output logic              intr
`ifdef DMAC_PAUSE_EN
  ,input logic              pause
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, READ, WAIT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [SIZE_W-1:0] remaining;
  logic [DATA_W-1:0] buffer;
  logic done_r, hold, last;
`ifdef DMAC_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign last = remaining == SIZE_W'(1);
  always_comb begin
    nxt = state;
    busy = 1'b0;
    m_req = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_dout = '0;
    intr = 1'b0;
    done = done_r;
    case (state)
      IDLE: nxt = op_start ? (data_size == '0 ? DONE : REQ) : IDLE;
      REQ: begin
        busy = 1'b1;
        m_req = !hold;
        nxt = (m_grant && !hold) ? READ : REQ;
      end
      READ: begin
        busy = 1'b1;
        m_req = 1'b1;
        m_addr = src_ptr;
        nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        m_req = 1'b1;
        nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        m_req = 1'b1;
        m_we = 1'b1;
        m_addr = dst_ptr;
        m_dout = buffer;
        nxt = last ? DONE : (m_grant && !hold) ? READ : REQ;
      end
      DONE: begin
        intr = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // completion in the DONE cycle outranks a concurrent op_clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      remaining <= '0;
      buffer <= '0;
      done_r <= 1'b0;
    end else begin
      state <= nxt;
      done_r <= (nxt == DONE) || (done_r && !(op_clear && state != DONE));
      if (state == IDLE && op_start) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        remaining <= data_size;
      end
      if (state == WAIT) buffer <= m_din;
      if (state == WRITE) begin
        src_ptr <= src_ptr + ADDR_W'(1);
        dst_ptr <= dst_ptr + ADDR_W'(1);
        remaining <= remaining - SIZE_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmac_transfer_ctrl.sv
// tb_dmac_transfer_ctrl: randomized and directed checks of dmac_transfer_ctrl against a word-level model.
module tb_dmac_transfer_ctrl;
  logic clk = 0, reset_n = 0, op_start = 0, op_clear = 0, m_grant = 0;
  logic [7:0] src_addr = 0, dst_addr = 0, data_size = 0, m_addr;
  logic m_req, m_we, busy, done, intr;
  logic [31:0] m_dout, m_din = 0;
  logic [31:0] mem [256];
`ifdef DMAC_PAUSE_EN
  logic pause = 0;
`endif
  typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t exq[$];
  int wr_cyc[$];
  int total = 0, bad = 0, cyc = 0, icnt = 0, ph = 0, c;
  bit done_m = 0, noreq = 0;

  dmac_transfer_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .src_addr(src_addr), .dst_addr(dst_addr), .data_size(data_size),
    .m_req(m_req), .m_grant(m_grant), .m_addr(m_addr), .m_we(m_we),
    .m_dout(m_dout), .m_din(m_din), .busy(busy), .done(done), .intr(intr)
`ifdef DMAC_PAUSE_EN
    , .pause(pause)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) m_din <= mem[m_addr];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", n, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ph: 0 idle, 1 transfer active, 2 completion cycle; exq holds the writes still owed
  always @(negedge clk) begin
    logic fin;
    int nph;
    logic [7:0] a;
    fin = 0;
    if (!reset_n) begin
      chk("reset_outputs", {m_req, m_we, busy, done, intr, m_addr, m_dout}, 0);
      ph = 0;
      done_m = 0;
      exq.delete();
    end else begin
      chk("busy", busy, ph == 1);
      if (!noreq) chk("m_req", m_req, ph == 1);
      chk("intr", intr, ph == 2);
      chk("done", done, done_m);
      if (intr) icnt++;
      if (m_we) begin
        if (exq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got addr=%0h data=%0h exp no write", m_addr, m_dout);
        end else begin
          chk("wr_addr", m_addr, exq[0].a);
          chk("wr_data", m_dout, exq[0].d);
          void'(exq.pop_front());
          wr_cyc.push_back(cyc);
          fin = exq.size() == 0;
        end
      end
      nph = ph;
      if (ph == 0 && op_start) begin
        nph = data_size == 0 ? 2 : 1;
        for (int i = 0; i < int'(data_size); i++) begin
          a = src_addr + 8'(i);
          exq.push_back('{a: dst_addr + 8'(i), d: mem[a]});
        end
      end else if (ph == 1 && fin) nph = 2;
      else if (ph == 2) nph = 0;
      done_m = (nph == 2 || ph == 2) ? 1'b1 : op_clear ? 1'b0 : done_m;
      ph = nph;
    end
  end

  task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    src_addr = s;
    dst_addr = d;
    data_size = n;
    op_start = 1;
    wr_cyc.delete();
    c = cyc;
    tick();
    op_start = 0;
  endtask

  task automatic run(input bit rnd, input int lim);
    int k;
    k = 0;
    while (ph != 0 && k < lim) begin
      if (rnd) begin
        m_grant = $urandom_range(0, 3) != 0;
        op_clear = $urandom_range(0, 7) == 0;
        op_start = $urandom_range(0, 9) == 0;
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        data_size = 8'($urandom_range(0, 6));
      end
      tick();
      k++;
    end
    op_start = 0;
    op_clear = 0;
    chk("finished_in_budget", ph == 0, 1);
    if (ph != 0) begin
      reset_n = 0;
      tick();
      reset_n = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hAAAA_0001;
    mem[8'h11] = 32'hBBBB_0002;
    mem[8'h12] = 32'hCCCC_0003;
    repeat (3) tick();
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_req", m_req, 0);
      chk("idle_busy", busy, 0);
      tick();
    end
    m_grant = 1;
    start(8'h10, 8'h80, 3);
    run(0, 60);
    chk("t1_nwr", wr_cyc.size(), 3);
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++) chk("t1_wr_cycle", wr_cyc[i] - c, 4 + 3 * i);
    chk("t1_intr_pulses", icnt, 1);
    chk("t1_done_sticky", done, 1);
    op_clear = 1;
    tick();
    op_clear = 0;
    chk("t1_done_cleared", done, 0);
    start(8'h40, 8'h50, 0);
    chk("sz0_intr", intr, 1);
    chk("sz0_done", done, 1);
    chk("sz0_req", m_req, 0);
    tick();
    chk("sz0_intr_off", intr, 0);
    chk("sz0_nwr", wr_cyc.size(), 0);
    start(8'h10, 8'h40, 4);
    for (int k = 1; k <= 20; k++) begin
      m_grant = !(k >= 7 && k <= 11);
      @(negedge clk);
      if (k >= 8 && k <= 11) begin
        chk("drop_req_held", m_req, 1);
        chk("drop_no_we", m_we, 0);
      end
      if (k == 13) chk("drop_resume_addr", {m_we, m_addr}, {1'b0, 8'h12});
      tick();
    end
    m_grant = 1;
    run(0, 40);
    chk("drop_nwr", wr_cyc.size(), 4);
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) chk("drop_wr_cycle", wr_cyc[i] - c, i < 2 ? 4 + 3 * i : 15 + 3 * (i - 2));
    start(8'hFE, 8'h20, 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) chk("wrap_rd0", {m_we, m_addr}, {1'b0, 8'hFE});
      if (k == 5) chk("wrap_rd1", {m_we, m_addr}, {1'b0, 8'hFF});
      if (k == 8) chk("wrap_rd2", {m_we, m_addr}, {1'b0, 8'h00});
      tick();
    end
    run(0, 40);
    start(8'h30, 8'h90, 3);
    repeat (5) tick();
    reset_n = 0;
    #1;
    chk("midrst_outputs", {m_req, m_we, busy, done, intr, m_addr, m_dout}, 0);
    tick();
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_we", m_we, 0);
      tick();
    end
    chk("midrst_nwr", wr_cyc.size(), 1);
`ifdef DMAC_PAUSE_EN
    noreq = 1;
    start(8'h50, 8'h60, 2);
    for (int k = 1; k <= 16; k++) begin
      pause = k >= 4 && k <= 8;
      @(negedge clk);
      if (k >= 5 && k <= 8) chk("pause_quiet", {m_req, m_we}, 0);
      tick();
    end
    pause = 0;
    run(0, 20);
    noreq = 0;
    chk("pause_nwr", wr_cyc.size(), 2);
    for (int i = 0; i < 2 && i < wr_cyc.size(); i++) chk("pause_wr_cycle", wr_cyc[i] - c, i == 0 ? 4 : 12);
`endif
    for (int t = 0; t < 40; t++) begin
      m_grant = $urandom_range(0, 3) != 0;
      start(8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)));
      run(1, 300);
      repeat ($urandom_range(0, 3)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
